sat_accumulator: RTL and testbench

- Multi-cycle accumulate stage built around one `Adder_16bit` instance.
- Accepts a command (operand count, add/subtract mode), then consumes a stream of 16-bit signed operands over a valid/ready handshake.
- Keeps a running saturating sum or difference, starting from 0.
- Presents the final result plus a sticky overflow flag over an output valid/ready handshake.
- Sits between the operand source (register read / load path) and writeback, as the sequential consumer of the saturating adder.

---
 rtl/sat_accumulator.sv | 164 ++++++++++++++++
 tb/tb_sat_accumulator.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sat_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : sat_accumulator (with helper Adder_16bit)
//  Purpose  : Multi-cycle saturating accumulate stage. A command (Len, Sub)
//             is taken in IDLE, then Len signed operands are consumed over a
//             valid/ready handshake and folded into a running saturating
//             sum/difference starting from 0. The final value and a sticky
//             overflow flag are offered over an output valid/ready handshake.
//  Ports    : clk, rst (async, active-high)
//             Start, Len[CNT_W-1:0], Sub        - command, sampled in IDLE
//             InValid, InData[WIDTH-1:0], InReady - operand stream
//             OutValid, OutReady, Result, Overflow - result handshake
//             Busy                               - state != IDLE
//  Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  Adder_16bit : combinational saturating add/subtract.
//  Ports : A, B (signed operands), Sub (0: A+B, 1: A-B),
//          Sum (saturated result), Overflow (this step saturated)
// ----------------------------------------------------------------------------
module Adder_16bit #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sub,
  output logic [WIDTH-1:0] Sum,
  output logic             Overflow
);

  logic [WIDTH-1:0] wrap_sum;
  logic             eff_sign;

  always_comb begin
    wrap_sum = Sub ? (A - B) : (A + B);
    // Sign of the operand actually added: subtracting flips B's sign.
    eff_sign = B[WIDTH-1] ^ Sub;
    Overflow = (eff_sign == A[WIDTH-1]) && (wrap_sum[WIDTH-1] != A[WIDTH-1]);
    if (Overflow) begin
      // Saturate toward the side the accumulator was already on.
      Sum = A[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      Sum = wrap_sum;
    end
  end

endmodule

// ----------------------------------------------------------------------------
//  sat_accumulator : top level
// ----------------------------------------------------------------------------
module sat_accumulator #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [CNT_W-1:0] Len,
  input  logic             Sub,
  input  logic             InValid,
  input  logic [WIDTH-1:0] InData,
  output logic             InReady,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Result,
  output logic             Overflow,
  output logic             Busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             sub_q, sub_d;
  logic             sticky_q, sticky_d;

  logic [WIDTH-1:0] add_sum;
  logic             add_ovf;

  Adder_16bit #(
    .WIDTH (WIDTH)
  ) u_adder (
    .A        (acc_q),
    .B        (InData),
    .Sub      (sub_q),
    .Sum      (add_sum),
    .Overflow (add_ovf)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    sub_d    = sub_q;
    sticky_d = sticky_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          acc_d    = '0;
          sticky_d = 1'b0;
          if (Len != '0) begin
            rem_d   = Len;
            sub_d   = Sub;
            state_d = ST_ACC;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_ACC: begin
        // InReady is always high here, so InValid alone marks an accepted beat.
        if (InValid) begin
          acc_d    = add_sum;
          sticky_d = sticky_q | add_ovf;
          rem_d    = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (OutReady) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      rem_q    <= '0;
      sub_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      sub_q    <= sub_d;
      sticky_q <= sticky_d;
    end
  end

  // Outputs come straight from registers or decoded state only, so reset
  // clears them immediately and no input reaches an output combinationally.
  assign InReady  = (state_q == ST_ACC);
  assign OutValid = (state_q == ST_DONE);
  assign Busy     = (state_q != ST_IDLE);
  assign Result   = acc_q;
  assign Overflow = sticky_q;

endmodule
`default_nettype wire

// File: tb/tb_sat_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sat_accumulator
//  Purpose  : Self-checking bench for sat_accumulator. A table of directed
//             commands with hand-computed results is applied back-to-back,
//             followed by hand-written sequences for input gaps, output
//             backpressure, Len==0 and asynchronous reset mid-command.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sat_accumulator;

  localparam int WIDTH = 16;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             Start;
  logic [CNT_W-1:0] Len;
  logic             Sub;
  logic             InValid;
  logic [WIDTH-1:0] InData;
  logic             InReady;
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] Result;
  logic             Overflow;
  logic             Busy;

  int tests_run;
  int tests_failed;

  sat_accumulator #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .Start    (Start),
    .Len      (Len),
    .Sub      (Sub),
    .InValid  (InValid),
    .InData   (InData),
    .InReady  (InReady),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Result   (Result),
    .Overflow (Overflow),
    .Busy     (Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [CNT_W-1:0] len;
    logic             sub;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic [WIDTH-1:0] exp_res;
    logic             exp_ovf;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic run_vec(input int idx, input vec_t v);
    logic [WIDTH-1:0] d [3];
    d[0] = v.d0; d[1] = v.d1; d[2] = v.d2;
    @(negedge clk);
    Start = 1'b1; Len = v.len; Sub = v.sub; OutReady = 1'b0;
    @(negedge clk);
    Start = 1'b0; Len = '0; Sub = 1'b0;
    check($sformatf("v%0d_inready", idx), WIDTH'(InReady), WIDTH'(1));
    for (int i = 0; i < int'(v.len); i++) begin
      if (i > 0) @(negedge clk);
      InValid = 1'b1; InData = d[i];
    end
    @(negedge clk);
    InValid = 1'b0; InData = '0;
    check($sformatf("v%0d_outvalid", idx), WIDTH'(OutValid), WIDTH'(1));
    check($sformatf("v%0d_result", idx), Result, v.exp_res);
    check($sformatf("v%0d_overflow", idx), WIDTH'(Overflow), WIDTH'(v.exp_ovf));
    OutReady = 1'b1;
    @(negedge clk);
    OutReady = 1'b0;
    check($sformatf("v%0d_busy_after", idx), WIDTH'(Busy), WIDTH'(0));
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    vecs[0] = '{len: 4'd3, sub: 1'b0, d0: 16'h0005, d1: 16'h0010, d2: 16'hFFFE,
                exp_res: 16'h0013, exp_ovf: 1'b0};
    vecs[1] = '{len: 4'd3, sub: 1'b0, d0: 16'h7FF0, d1: 16'h0020, d2: 16'hFFFF,
                exp_res: 16'h7FFE, exp_ovf: 1'b1};
    vecs[2] = '{len: 4'd1, sub: 1'b1, d0: 16'h8000, d1: 16'h0000, d2: 16'h0000,
                exp_res: 16'h7FFF, exp_ovf: 1'b1};
    vecs[3] = '{len: 4'd2, sub: 1'b1, d0: 16'h0001, d1: 16'h8000, d2: 16'h0000,
                exp_res: 16'h7FFF, exp_ovf: 1'b0};
    // 0x8001 + 0xFFF0 underflows to 0x8000, then +5 recovers to 0x8005.
    vecs[4] = '{len: 4'd3, sub: 1'b0, d0: 16'h8001, d1: 16'hFFF0, d2: 16'h0005,
                exp_res: 16'h8005, exp_ovf: 1'b1};

    rst = 1'b1; Start = 1'b0; Len = '0; Sub = 1'b0;
    InValid = 1'b0; InData = '0; OutReady = 1'b0;
    #12;
    check("rst_inready",  WIDTH'(InReady),  WIDTH'(0));
    check("rst_outvalid", WIDTH'(OutValid), WIDTH'(0));
    check("rst_busy",     WIDTH'(Busy),     WIDTH'(0));
    check("rst_result",   Result,           16'h0000);
    check("rst_overflow", WIDTH'(Overflow), WIDTH'(0));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // Input gap: Len=2, 1 then 3 idle cycles then 2.
    @(negedge clk);
    Start = 1'b1; Len = 4'd2; Sub = 1'b0;
    @(negedge clk);
    Start = 1'b0; InValid = 1'b1; InData = 16'h0001;
    for (int g = 0; g < 3; g++) begin
      @(negedge clk);
      InValid = 1'b0; InData = 16'h1111;
      check($sformatf("gap%0d_inready", g), WIDTH'(InReady), WIDTH'(1));
      check($sformatf("gap%0d_outvalid", g), WIDTH'(OutValid), WIDTH'(0));
    end
    @(negedge clk);
    InValid = 1'b1; InData = 16'h0002;
    check("gap_inready_last", WIDTH'(InReady), WIDTH'(1));
    @(negedge clk);
    InValid = 1'b0;
    check("gap_outvalid", WIDTH'(OutValid), WIDTH'(1));
    check("gap_result", Result, 16'h0003);

    // Output backpressure: hold 5 cycles with a stray Start in the window.
    for (int h = 0; h < 5; h++) begin
      Start = (h == 2); Len = 4'd3;
      @(negedge clk);
      check($sformatf("hold%0d_outvalid", h), WIDTH'(OutValid), WIDTH'(1));
      check($sformatf("hold%0d_result", h), Result, 16'h0003);
      check($sformatf("hold%0d_overflow", h), WIDTH'(Overflow), WIDTH'(0));
      check($sformatf("hold%0d_busy", h), WIDTH'(Busy), WIDTH'(1));
    end
    // Release with Start high in the handshake cycle: it must be ignored.
    OutReady = 1'b1; Start = 1'b1; Len = 4'd3;
    @(negedge clk);
    Start = 1'b0; Len = '0; OutReady = 1'b0;
    check("release_busy", WIDTH'(Busy), WIDTH'(0));
    check("release_outvalid", WIDTH'(OutValid), WIDTH'(0));
    @(negedge clk);
    check("release_no_cmd", WIDTH'(Busy), WIDTH'(0));

    // Len == 0.
    Start = 1'b1; Len = 4'd0; OutReady = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    check("len0_outvalid", WIDTH'(OutValid), WIDTH'(1));
    check("len0_result", Result, 16'h0000);
    check("len0_overflow", WIDTH'(Overflow), WIDTH'(0));
    @(negedge clk);
    OutReady = 1'b0;
    check("len0_busy_after", WIDTH'(Busy), WIDTH'(0));

    // Asynchronous reset after one of three beats.
    Start = 1'b1; Len = 4'd3; Sub = 1'b0;
    @(negedge clk);
    Start = 1'b0; InValid = 1'b1; InData = 16'h8000;
    @(negedge clk);
    InValid = 1'b0;
    check("pre_rst_result", Result, 16'h8000);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_inready",  WIDTH'(InReady),  WIDTH'(0));
    check("arst_busy",     WIDTH'(Busy),     WIDTH'(0));
    check("arst_outvalid", WIDTH'(OutValid), WIDTH'(0));
    check("arst_result",   Result,           16'h0000);
    check("arst_overflow", WIDTH'(Overflow), WIDTH'(0));
    #1 rst = 1'b0;
    run_vec(9, '{len: 4'd1, sub: 1'b0, d0: 16'h0007, d1: 16'h0000, d2: 16'h0000,
                 exp_res: 16'h0007, exp_ovf: 1'b0});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Safety net: the directed sequence above is far shorter than this.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, limit 100000 ns");
    $fatal(1);
  end

endmodule
`default_nettype wire
